// File: rtl/mem_pkg.sv
// Shared constants and types for the four-bank interleaved memory responder.
package mem_pkg;

  // Word-interleaved banking: addr[0] is the byte lane, addr[2:1] picks the
  // bank, and the word index within the bank starts at addr[3].
  localparam int BANKS     = 4;
  localparam int BANK_W    = 2;
  localparam int BANK_LSB  = 1;
  localparam int INDEX_LSB = BANK_LSB + BANK_W;

  localparam int DEF_BANK_CYCLES = 4;
  localparam int DEF_RD_LAT      = 2;

  typedef logic [BANK_W-1:0] bank_t;

  // One read in flight. The word index is consumed by the bank's registered
  // read port at the accept edge, so only the bank number travels with the
  // entry to steer the output mux one cycle later.
  typedef struct packed {
    logic  valid;
    bank_t bank;
  } rd_entry_t;

endpackage

// File: rtl/mem_bank.sv
// One memory bank: storage, occupancy counter/busy flag, write port and a
// registered read port.
module mem_bank
  import mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 256,
  parameter int BANK_CYCLES = DEF_BANK_CYCLES,
  parameter int IDX_W       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(BANK_CYCLES);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  // Storage is deliberately not reset so its contents survive rst_n; the read
  // register captures the word as it stands at the accept edge.
  always_ff @(posedge clk) begin
    if (acc_i && we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
    if (acc_i && !we_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  // Occupancy: reload on every accepted access, then count down to idle.
  always_comb begin
    cnt_d = cnt_q;
    if (acc_i) begin
      cnt_d = CNT_W'(BANK_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register, cleared by reset so the bank is immediately free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o  = (cnt_q != '0);
  assign rdata_o = rdata_q;

endmodule

// File: rtl/banked_mem_responder.sv
// Four-bank word-interleaved memory model answering a cache controller's
// rd/wr requests with per-bank occupancy and fixed pipelined read latency.
module banked_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int WORDS_PER_BANK = 256,
  parameter int BANK_CYCLES    = DEF_BANK_CYCLES,
  parameter int RD_LAT         = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_in_i,
  input  logic              wr_i,
  input  logic              rd_i,
  output logic [DATA_W-1:0] data_out_o,
  output logic              data_valid_o,
  output logic              stall_o,
  output logic [BANKS-1:0]  busy_o,
  output logic              err_o
);

  localparam int IDX_W = $clog2(WORDS_PER_BANK);
  // The bank's read register is the first latency stage; the remaining
  // RD_LAT-1 stages live here, the last of which is the output register.
  // RD_LAT must therefore be at least 2.
  localparam int DL = RD_LAT - 1;

  bank_t             bank_sel;
  logic [IDX_W-1:0]  idx;
  logic              req;
  logic              accept;
  logic [BANKS-1:0]  bank_acc;
  logic [DATA_W-1:0] bank_rdata [BANKS];
  rd_entry_t         s1_q;
  rd_entry_t         s1_d;
  logic [DL-1:0]              dv_q;
  logic [DL-1:0][DATA_W-1:0]  dd_q;
  logic              unused_addr_hi;

  assign bank_sel = addr_i[BANK_LSB +: BANK_W];
  assign idx      = addr_i[INDEX_LSB +: IDX_W];
  // Upper address bits only alias; fold them so they are visibly consumed.
  assign unused_addr_hi = ^addr_i[ADDR_W-1:INDEX_LSB+IDX_W];

  // Classify the present request: illegal, refused by a busy bank, or taken.
  always_comb begin
    req     = rd_i ^ wr_i;
    err_o   = (rd_i & wr_i) | ((rd_i | wr_i) & addr_i[0]);
    stall_o = req & ~err_o & busy_o[bank_sel];
    accept  = req & ~err_o & ~busy_o[bank_sel];
  end

  for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
    assign bank_acc[gi] = accept && (bank_sel == bank_t'(gi));

    mem_bank #(
      .DATA_W      (DATA_W),
      .DEPTH       (WORDS_PER_BANK),
      .BANK_CYCLES (BANK_CYCLES),
      .IDX_W       (IDX_W)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .acc_i   (bank_acc[gi]),
      .we_i    (wr_i),
      .idx_i   (idx),
      .wdata_i (data_in_i),
      .rdata_o (bank_rdata[gi]),
      .busy_o  (busy_o[gi])
    );
  end

  // Next entry for the first pipeline stage: a read was taken this cycle.
  always_comb begin
    s1_d.valid = accept & rd_i;
    s1_d.bank  = bank_sel;
  end

  // First stage remembers which bank holds the read result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else begin
      s1_q <= s1_d;
    end
  end

  // Remaining latency stages: mux the bank result in, then shift. Data only
  // moves with a valid so the last stage holds its previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q <= '0;
      dd_q <= '0;
    end else begin
      dv_q[0] <= s1_q.valid;
      if (s1_q.valid) begin
        dd_q[0] <= bank_rdata[s1_q.bank];
      end
      for (int k = 1; k < DL; k++) begin
        dv_q[k] <= dv_q[k-1];
        if (dv_q[k-1]) begin
          dd_q[k] <= dd_q[k-1];
        end
      end
    end
  end

  assign data_valid_o = dv_q[DL-1];
  assign data_out_o   = dd_q[DL-1];

endmodule

// File: tb/tb_banked_mem_responder.sv
// Self-checking bench: directed scenarios plus random traffic against a
// cycle-numbered reference model of the banked memory.
module tb_banked_mem_responder;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int WORDS  = 256;
  localparam int BC     = 4;
  localparam int RL     = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [ADDR_W-1:0] addr_i = '0;
  logic [DATA_W-1:0] data_in_i = '0;
  logic              wr_i = 1'b0;
  logic              rd_i = 1'b0;
  logic [DATA_W-1:0] data_out_o;
  logic              data_valid_o;
  logic              stall_o;
  logic [3:0]        busy_o;
  logic              err_o;

  banked_mem_responder #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .WORDS_PER_BANK (WORDS),
    .BANK_CYCLES    (BC),
    .RD_LAT         (RL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr_i       (addr_i),
    .data_in_i    (data_in_i),
    .wr_i         (wr_i),
    .rd_i         (rd_i),
    .data_out_o   (data_out_o),
    .data_valid_o (data_valid_o),
    .stall_o      (stall_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  // Reference model state. Time is counted in rising edges; a bank accessed
  // at edge E is occupied up to and including the cycle after edge E+BC-2,
  // and a read taken at edge E is delivered after edge E+RL-1.
  typedef struct {
    int          due;
    logic [15:0] data;
    bit          known;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mmem  [4][WORDS];
  bit          known [4][WORDS];
  int          free_edge [4];
  int          now_edge = 0;
  logic [15:0] last_data = '0;
  bit          last_known = 1'b1;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, now_edge);
    end
  endtask

  // Registered outputs, sampled just after a rising edge.
  task automatic check_outputs();
    bit   exp_v;
    exp_t item;
    exp_v = (exp_q.size() > 0) && (exp_q[0].due == now_edge);
    check_eq("data_valid", data_valid_o, exp_v);
    if (exp_v) begin
      item       = exp_q.pop_front();
      last_data  = item.data;
      last_known = item.known;
    end
    if (last_known) check_eq("data_out", data_out_o, last_data);
  endtask

  // Present one request for one cycle; called and returns at posedge+1.
  task automatic drive_cycle(input logic r, input logic w, input logic [15:0] a,
                             input logic [15:0] d, output bit acc);
    int       b;
    int       i;
    bit       m_req;
    bit       m_err;
    bit       m_stall;
    logic [3:0] m_busy;
    rd_i = r; wr_i = w; addr_i = a; data_in_i = d;
    #1;
    b = (int'(a) >> 1) % 4;
    i = (int'(a) >> 3) % WORDS;
    for (int k = 0; k < 4; k++) m_busy[k] = (now_edge <= free_edge[k]);
    m_req   = r ^ w;
    m_err   = (r && w) || ((r || w) && a[0]);
    m_stall = m_req && !m_err && m_busy[b];
    acc     = m_req && !m_err && !m_stall;
    check_eq("err", err_o, m_err);
    check_eq("stall", stall_o, m_stall);
    check_eq("busy", busy_o, m_busy);
    if (r || w)
      $display("[TB] edge %0d rd=%0b wr=%0b addr=%h wdata=%h -> %s", now_edge, r, w, a, d,
               acc ? "accept" : (m_err ? "illegal" : "stall"));
    @(posedge clk);
    now_edge++;
    if (acc) begin
      free_edge[b] = now_edge + BC - 2;
      if (w) begin
        mmem[b][i]  = d;
        known[b][i] = 1'b1;
      end else begin
        exp_q.push_back('{due: now_edge + RL - 1, data: mmem[b][i], known: known[b][i]});
      end
    end
    #1;
    check_outputs();
  endtask

  // Hold a request until the model says it was taken (bounded retries).
  task automatic issue(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    bit acc;
    int tries;
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 16) begin
      drive_cycle(r, w, a, d, acc);
      tries++;
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) drive_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, acc);
  endtask

  // Asynchronous reset: in-flight reads vanish, banks free at once, memory kept.
  task automatic do_reset();
    rd_i = 1'b0; wr_i = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) free_edge[k] = -100;
    last_data  = '0;
    last_known = 1'b1;
    #1;
    check_eq("rst_busy", busy_o, 4'b0000);
    check_eq("rst_valid", data_valid_o, 1'b0);
    check_eq("rst_dout", data_out_o, 16'h0000);
    repeat (2) begin
      @(posedge clk);
      now_edge++;
      #1;
      check_eq("rst_hold_valid", data_valid_o, 1'b0);
      check_eq("rst_hold_busy", busy_o, 4'b0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset released at edge %0d", now_edge);
    @(posedge clk);
    now_edge++;
    #1;
    check_outputs();
  endtask

  initial begin
    int          op;
    logic [15:0] a;
    logic        r;
    logic        w;
    bit          acc;

    #3;
    do_reset();

    // Basic write then read after the bank frees up.
    issue(1'b0, 1'b1, 16'h0010, 16'h1234);
    issue(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(3);

    // Fill one word in every bank, plus a second word in bank 0.
    issue(1'b0, 1'b1, 16'h0000, 16'hA000);
    issue(1'b0, 1'b1, 16'h0002, 16'hA111);
    issue(1'b0, 1'b1, 16'h0004, 16'hA222);
    issue(1'b0, 1'b1, 16'h0006, 16'hA333);
    issue(1'b0, 1'b1, 16'h0008, 16'h5555);
    idle(4);

    // Back-to-back reads across all four banks.
    drive_cycle(1'b1, 1'b0, 16'h0000, 16'h0000, acc);
    drive_cycle(1'b1, 1'b0, 16'h0002, 16'h0000, acc);
    drive_cycle(1'b1, 1'b0, 16'h0004, 16'h0000, acc);
    drive_cycle(1'b1, 1'b0, 16'h0006, 16'h0000, acc);
    idle(4);

    // Same-bank conflict: second read stalls until the bank frees.
    issue(1'b1, 1'b0, 16'h0000, 16'h0000);
    issue(1'b1, 1'b0, 16'h0008, 16'h0000);
    idle(3);

    // Illegal requests leave no trace.
    drive_cycle(1'b1, 1'b1, 16'h0010, 16'hDEAD, acc);
    drive_cycle(1'b1, 1'b0, 16'h0003, 16'h0000, acc);
    drive_cycle(1'b0, 1'b1, 16'h0011, 16'hDEAD, acc);
    idle(2);
    issue(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(3);

    // Reset the cycle after a read is accepted.
    issue(1'b1, 1'b0, 16'h0010, 16'h0000);
    do_reset();
    idle(3);
    issue(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(3);

    // Upper address bits alias onto the same word.
    issue(1'b0, 1'b1, 16'h0810, 16'hBEEF);
    issue(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(3);

    // Random traffic over a small index window with random aliasing bits.
    for (int n = 0; n < 1500; n++) begin
      op      = $urandom_range(0, 99);
      a       = 16'($urandom);
      a[10:3] = 8'($urandom_range(0, 7));
      a[0]    = 1'b0;
      r       = 1'b0;
      w       = 1'b0;
      if (op < 40) r = 1'b1;
      else if (op < 70) w = 1'b1;
      else if (op < 75) begin r = 1'b1; w = 1'b1; end
      else if (op < 80) begin r = 1'b1; a[0] = 1'b1; end
      drive_cycle(r, w, a, 16'($urandom), acc);
      if (n == 700) do_reset();
    end
    idle(RL + 2);
    check_eq("drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
